// File: rtl/alu_inst_encoder.sv
// alu_inst_encoder
// Turns ALU-op requests into RV32I R-type / I-type / LUI instruction words,
// buffers them in a small circular FIFO and streams them out with
// sequential byte addresses for the instruction-memory loader.
//
// Both ports use the same handshake: a transfer happens on a rising clock
// edge when valid && ready are both high. valid is held with stable payload
// until it is taken. ready never depends on the other side's valid in the
// same cycle.
module alu_inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [3:0]                   i_alu_op,
  input  logic                         i_imm_mode,
  input  logic [4:0]                   i_rd,
  input  logic [4:0]                   i_rs1,
  input  logic [4:0]                   i_rs2,
  input  logic [19:0]                  i_imm,
  output logic                         o_inst_valid,
  input  logic                         i_inst_ready,
  output logic [31:0]                  o_inst,
  output logic [31:0]                  o_inst_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   addr;
  logic          err;

  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          is_shift;
  logic          illegal;
  logic [31:0]   enc_word;
  logic          req_hs;
  logic          push;
  logic          pop;

  // Field lookup for the requested operation and legality check.
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (i_alu_op)
      OP_ADD:  funct3 = 3'b000;
      OP_SUB: begin
        funct3  = 3'b000;
        funct7  = 7'b0100000;
        // There is no SUBI in RV32I.
        illegal = i_imm_mode;
      end
      OP_SLL: begin
        funct3   = 3'b001;
        is_shift = 1'b1;
      end
      OP_SLT:  funct3 = 3'b010;
      OP_SLTU: funct3 = 3'b011;
      OP_XOR:  funct3 = 3'b100;
      OP_SRL: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
      end
      OP_SRA: begin
        funct3   = 3'b101;
        funct7   = 7'b0100000;
        is_shift = 1'b1;
      end
      OP_OR:   funct3 = 3'b110;
      OP_AND:  funct3 = 3'b111;
      OP_LUI:  funct3 = 3'b000;
      default: illegal = 1'b1;
    endcase
  end

  // Instruction word assembly for the three supported formats.
  always_comb begin
    enc_word = 32'h0;
    if (i_alu_op == OP_LUI) begin
      enc_word = {i_imm, i_rd, OPC_LUI};
    end else if (!i_imm_mode) begin
      enc_word = {funct7, i_rs2, i_rs1, funct3, i_rd, OPC_R};
    end else if (is_shift) begin
      enc_word = {funct7, i_imm[4:0], i_rs1, funct3, i_rd, OPC_I};
    end else begin
      enc_word = {i_imm[11:0], i_rs1, funct3, i_rd, OPC_I};
    end
  end

  // Handshake qualification; illegal requests complete but are dropped.
  always_comb begin
    o_req_ready  = (count != CW'(DEPTH));
    o_inst_valid = (count != '0);
    req_hs       = i_req_valid && o_req_ready;
    push         = req_hs && !illegal;
    pop          = o_inst_valid && i_inst_ready;
    o_inst       = o_inst_valid ? mem[rd_ptr] : 32'h0;
    o_inst_addr  = addr;
    o_count      = count;
    o_err        = err;
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Pointers, occupancy, output address counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr   <= BASE_ADDR;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr   <= addr + 32'd4;
      end
      count <= count + CW'(push) - CW'(pop);
      if (req_hs && illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_inst_encoder.sv
// tb_alu_inst_encoder
// Directed test-plan sequences followed by randomized traffic, all checked
// cycle by cycle against a queue-based reference of the encoder.
module tb_alu_inst_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          CW        = $clog2(DEPTH+1);

  logic          i_clk;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [3:0]    i_alu_op;
  logic          i_imm_mode;
  logic [4:0]    i_rd;
  logic [4:0]    i_rs1;
  logic [4:0]    i_rs2;
  logic [19:0]   i_imm;
  logic          o_inst_valid;
  logic          i_inst_ready;
  logic [31:0]   o_inst;
  logic [31:0]   o_inst_addr;
  logic [CW-1:0] o_count;
  logic          o_err;

  alu_inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_alu_op     (i_alu_op),
    .i_imm_mode   (i_imm_mode),
    .i_rd         (i_rd),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_imm        (i_imm),
    .o_inst_valid (o_inst_valid),
    .i_inst_ready (i_inst_ready),
    .o_inst       (o_inst),
    .o_inst_addr  (o_inst_addr),
    .o_count      (o_count),
    .o_err        (o_err)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_err;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder: builds the word field by field with plain arithmetic.
  function automatic logic [31:0] ref_encode(input int op, input int mode, input int rd,
                                             input int rs1, input int rs2, input int imm,
                                             output bit legal);
    int     f3_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    longint w;
    longint f7;
    legal = (op <= 10) && !(op == 1 && mode != 0);
    if (!legal) return 32'h0;
    if (op == 10) begin
      w = longint'(imm % 1048576) * 4096 + rd * 128 + 55;
      return w[31:0];
    end
    f7 = ((op == 1) || (op == 7)) ? 32 : 0;
    if (mode == 0) begin
      w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3_tab[op] * 4096 + rd * 128 + 51;
    end else if (op == 2 || op == 6 || op == 7) begin
      w = f7 * 33554432 + (imm % 32) * 1048576 + rs1 * 32768 + f3_tab[op] * 4096 + rd * 128 + 19;
    end else begin
      w = longint'(imm % 4096) * 1048576 + rs1 * 32768 + f3_tab[op] * 4096 + rd * 128 + 19;
    end
    return w[31:0];
  endfunction

  // Compares every visible output against the scoreboard.
  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".ready"}, 32'(o_req_ready), 32'(sz != DEPTH));
    check({tag, ".valid"}, 32'(o_inst_valid), 32'(sz != 0));
    check({tag, ".inst"},  o_inst, (sz != 0) ? exp_q[0] : 32'h0);
    check({tag, ".addr"},  o_inst_addr, exp_addr);
    check({tag, ".count"}, 32'(o_count), 32'(sz));
    check({tag, ".err"},   32'(o_err), 32'(exp_err));
  endtask

  // Driver: one clock cycle with the given inputs, starting and ending at a negedge.
  task automatic step(input string tag, input bit rst, input bit rv, input int op, input int mode,
                      input int rd, input int rs1, input int rs2, input int imm, input bit ir);
    bit          legal;
    bit          hs;
    bit          do_pop;
    logic [31:0] w;
    i_rst        = rst;
    i_req_valid  = rv;
    i_alu_op     = 4'(op);
    i_imm_mode   = 1'(mode);
    i_rd         = 5'(rd);
    i_rs1        = 5'(rs1);
    i_rs2        = 5'(rs2);
    i_imm        = 20'(imm);
    i_inst_ready = ir;
    w      = ref_encode(op, mode, rd, rs1, rs2, imm, legal);
    hs     = rv && (exp_q.size() != DEPTH);
    do_pop = ir && (exp_q.size() != 0);
    @(posedge i_clk);
    if (rst) begin
      exp_q.delete();
      exp_addr = BASE_ADDR;
      exp_err  = 1'b0;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        exp_addr = exp_addr + 32'd4;
      end
      if (hs) begin
        if (legal) exp_q.push_back(w);
        else exp_err = 1'b1;
      end
    end
    @(negedge i_clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit ir);
    step(tag, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, ir);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_addr = BASE_ADDR;
    exp_err  = 1'b0;
    i_rst = 1'b1; i_req_valid = 1'b0; i_alu_op = '0; i_imm_mode = 1'b0;
    i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_inst_ready = 1'b0;
    @(negedge i_clk);
    step("reset", 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    step("reset2", 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("reset.ready_lit", 32'(o_req_ready), 32'd1);
    check("reset.addr_lit", o_inst_addr, 32'h0);

    // ADD R-type, visible one cycle after the handshake.
    step("add", 1'b0, 1'b1, 0, 0, 1, 2, 3, 0, 1'b0);
    check("add.lit", o_inst, 32'h003100B3);
    check("add.addr_lit", o_inst_addr, 32'h0);
    idle("add_pop", 1'b1);

    // SUB, SRAI, ADDI, LUI queued under backpressure, then drained.
    step("sub",  1'b0, 1'b1, 1, 0, 5, 6, 7, 0, 1'b0);
    step("srai", 1'b0, 1'b1, 7, 1, 1, 1, 0, 20'h00003, 1'b0);
    step("addi", 1'b0, 1'b1, 0, 1, 1, 0, 0, 20'h00001, 1'b0);
    step("lui",  1'b0, 1'b1, 10, 0, 10, 0, 0, 20'h12345, 1'b0);
    check("sub.lit", o_inst, 32'h407302B3);
    check("full4.ready_lit", 32'(o_req_ready), 32'd0);
    idle("pop_sub", 1'b1);
    check("srai.lit", o_inst, 32'h4030D093);
    idle("pop_srai", 1'b1);
    check("addi.lit", o_inst, 32'h00100093);
    idle("pop_addi", 1'b1);
    check("lui.lit", o_inst, 32'h12345537);
    check("lui.addr_lit", o_inst_addr, 32'h00000010);
    idle("pop_lui", 1'b1);

    // Illegal requests: handshaken, dropped, sticky error, address kept.
    step("ill_subi", 1'b0, 1'b1, 1, 1, 3, 3, 3, 5, 1'b1);
    step("ill_op12", 1'b0, 1'b1, 12, 0, 3, 3, 3, 5, 1'b1);
    check("ill.err_lit", 32'(o_err), 32'd1);
    step("post_ill", 1'b0, 1'b1, 0, 1, 2, 0, 0, 20'h00005, 1'b0);
    check("post_ill.addr_lit", o_inst_addr, 32'h00000014);
    idle("post_ill_pop", 1'b1);

    // Fill under backpressure, then drain with simultaneous refill.
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b1, 0, 1, i + 1, 0, 0, i, 1'b0);
    check("fill.count_lit", 32'(o_count), 32'd4);
    step("full_hold", 1'b0, 1'b1, 0, 1, 9, 0, 0, 9, 1'b0);
    for (int i = 0; i < 8; i++) step("refill", 1'b0, 1'b1, 0, 1, i, i, 0, 100 + i, 1'b1);
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // Reset mid-stream with three words queued.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b0, 1'b1, 5, 0, i, i, i, 0, 1'b0);
    step("mid_rst", 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("mid_rst.count_lit", 32'(o_count), 32'd0);
    check("mid_rst.err_lit", 32'(o_err), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int op;
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 10)) : int'($urandom_range(11, 15));
      step("rand", ($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), op,
           int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 20'hFFFFF)),
           ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
